// File: rtl/reg_pipe_stage.sv
`timescale 1ns/1ps
// reg_pipe_stage
//   Elastic valid/ready pipeline stage register with a 2-entry skid buffer.
//   in_ready is decoded straight from the state register, so a downstream
//   stall propagates upstream one stage per cycle with no combinational
//   ready path through the stage.
//
//   Optional feature: define REG_PIPE_STATS_EN to add the stall_cnt port,
//   a saturating count of cycles with out_valid & !out_ready. Only rst
//   clears it.
//
// Parameters
//   W        payload width
//   RST_VAL  value on out_data after reset or flush
//   CNT_W    stall counter width (REG_PIPE_STATS_EN only)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous flush, squashes all held entries
//   in_valid   upstream payload available
//   in_ready   stage can accept (registered)
//   in_data    upstream payload
//   out_valid  out_data holds a valid payload
//   out_ready  downstream accepts out_data this cycle
//   out_data   payload to next stage
//   stall_cnt  stall cycle counter (REG_PIPE_STATS_EN only)
module reg_pipe_stage #(
  parameter int unsigned    W       = 96,
  parameter logic [W-1:0]   RST_VAL = '0,
  parameter int unsigned    CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data
`ifdef REG_PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  if (W < 1 || CNT_W < 1) begin : g_bad_param
    $error("reg_pipe_stage: W and CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           push, pop;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign out_data  = main_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a pop can move the state
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    // A pop in this cycle has already been sampled downstream; a push is
    // accepted but discarded along with everything held.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end
  end

`ifdef REG_PIPE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
